// File: rtl/lcd_dbg_scheduler.sv
// Purpose: time-shares the character LCD between NUM_SRC 32-bit debug words, streaming "R<k>=<8 hex>" frames.
// Latency: first char valid 2 cycles after a refresh request; 11 chars in 11 cycles with ready held high.
// Backpressure: per-char valid/ready, data/addr held while ready is low; LCD_DBG_CHG_ONLY_EN skips unchanged frames.
module lcd_dbg_scheduler #(
    parameter int NUM_SRC       = 4,
    parameter int REFRESH_CYC   = 2500000,
    parameter int ROTATE_FRAMES = 40
) (
    input  logic                   clk_in,
    input  logic                   reset_n,
    input  logic [NUM_SRC*32-1:0]  dbg_words,
    input  logic                   key_next,
    input  logic                   lcd_char_ready,
    output logic                   lcd_char_valid,
    output logic [7:0]             lcd_char_data,
    output logic [4:0]             lcd_char_addr,
    output logic [3:0]             cur_src,
    output logic                   frame_done
);

    localparam int TW  = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int FCW = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SNAP, ST_SEND} state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic [FCW-1:0] frame_cnt;
    logic           refresh_pend;
    logic           key_pend;
    logic [31:0]    snap;

    logic [3:0]     nxt_src;
    logic [31:0]    sel_word;
    logic           timer_wrap;
    logic           xfer;
    logic           last_xfer;
    logic           skip;
    logic           frame_tick;
    logic           rotate_hit;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] frame_char(input logic [4:0] idx, input logic [3:0] s,
                                              input logic [31:0] w);
        logic [7:0] c;
        case (idx)
            5'd0:    c = 8'h52;
            5'd1:    c = hex_ascii(s);
            5'd2:    c = 8'h3D;
            5'd3:    c = hex_ascii(w[31:28]);
            5'd4:    c = hex_ascii(w[27:24]);
            5'd5:    c = hex_ascii(w[23:20]);
            5'd6:    c = hex_ascii(w[19:16]);
            5'd7:    c = hex_ascii(w[15:12]);
            5'd8:    c = hex_ascii(w[11:8]);
            5'd9:    c = hex_ascii(w[7:4]);
            5'd10:   c = hex_ascii(w[3:0]);
            default: c = 8'h20;
        endcase
        return c;
    endfunction

    assign timer_wrap = (timer == TW'(REFRESH_CYC - 1));
    assign xfer       = (state == ST_SEND) && lcd_char_valid && lcd_char_ready;
    assign last_xfer  = xfer && (lcd_char_addr == 5'd10);
    assign rotate_hit = (ROTATE_FRAMES != 0) && (frame_cnt == FCW'(ROTATE_FRAMES - 1));
    assign frame_tick = last_xfer || skip;

    // Pending advance is applied in the same cycle the word is captured.
    always_comb begin
        nxt_src = cur_src;
        if (key_pend) begin
            nxt_src = (cur_src == 4'(NUM_SRC - 1)) ? 4'd0 : cur_src + 4'd1;
        end
    end

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (nxt_src == 4'(k)) begin
                sel_word = dbg_words[32*k +: 32];
            end
        end
    end

`ifdef LCD_DBG_CHG_ONLY_EN
    logic        have_last;
    logic [3:0]  last_src;
    logic [31:0] last_snap;

    assign skip = (state == ST_SNAP) && have_last && !key_pend &&
                  (nxt_src == last_src) && (sel_word == last_snap);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            have_last <= 1'b0;
            last_src  <= '0;
            last_snap <= '0;
        end else if (last_xfer) begin
            have_last <= 1'b1;
            last_src  <= cur_src;
            last_snap <= snap;
        end
    end
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            timer          <= '0;
            frame_cnt      <= '0;
            refresh_pend   <= 1'b1;
            key_pend       <= 1'b0;
            snap           <= '0;
            cur_src        <= '0;
            lcd_char_valid <= 1'b0;
            lcd_char_data  <= '0;
            lcd_char_addr  <= '0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            timer      <= timer_wrap ? '0 : timer + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (refresh_pend) begin
                        state <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    cur_src       <= nxt_src;
                    snap          <= sel_word;
                    refresh_pend  <= 1'b0;
                    key_pend      <= 1'b0;
                    lcd_char_addr <= '0;
                    if (skip) begin
                        state <= ST_IDLE;
                    end else begin
                        state          <= ST_SEND;
                        lcd_char_valid <= 1'b1;
                        lcd_char_data  <= frame_char(5'd0, nxt_src, sel_word);
                    end
                end
                ST_SEND: begin
                    if (last_xfer) begin
                        state          <= ST_IDLE;
                        lcd_char_valid <= 1'b0;
                        lcd_char_data  <= '0;
                        lcd_char_addr  <= '0;
                        frame_done     <= 1'b1;
                    end else if (xfer) begin
                        lcd_char_addr <= lcd_char_addr + 5'd1;
                        lcd_char_data <= frame_char(lcd_char_addr + 5'd1, cur_src, snap);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Later assignments win: any new request overrides the clear done in SNAP.
            if (frame_tick) begin
                if (rotate_hit) begin
                    frame_cnt    <= '0;
                    key_pend     <= 1'b1;
                    refresh_pend <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (key_next) begin
                key_pend     <= 1'b1;
                refresh_pend <= 1'b1;
                frame_cnt    <= '0;
            end
            if (timer_wrap) begin
                refresh_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_dbg_scheduler.sv
// Bench for lcd_dbg_scheduler: vector tables, hand sequences and a queue-based frame model under random stimulus.
module tb_lcd_dbg_scheduler;

    localparam int NUM_SRC     = 4;
    localparam int REFRESH_CYC = 40;
`ifdef LCD_DBG_CHG_ONLY_EN
    localparam int ROTATE_FRAMES = 0;
    localparam bit CHG = 1'b1;
`else
    localparam int ROTATE_FRAMES = 3;
    localparam bit CHG = 1'b0;
`endif

    logic                  clk_in;
    logic                  reset_n;
    logic [NUM_SRC*32-1:0] dbg_words;
    logic                  key_next;
    logic                  lcd_char_ready;
    logic                  lcd_char_valid;
    logic [7:0]            lcd_char_data;
    logic [4:0]            lcd_char_addr;
    logic [3:0]            cur_src;
    logic                  frame_done;

    lcd_dbg_scheduler #(
        .NUM_SRC(NUM_SRC), .REFRESH_CYC(REFRESH_CYC), .ROTATE_FRAMES(ROTATE_FRAMES)
    ) dut (
        .clk_in(clk_in), .reset_n(reset_n), .dbg_words(dbg_words), .key_next(key_next),
        .lcd_char_ready(lcd_char_ready), .lcd_char_valid(lcd_char_valid),
        .lcd_char_data(lcd_char_data), .lcd_char_addr(lcd_char_addr),
        .cur_src(cur_src), .frame_done(frame_done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frames as queues of characters ----------------
    logic [7:0]  mq[$];
    int          m_timer, m_fcnt, m_src, m_last_src;
    bit          m_rpend, m_kpend, m_snap, m_fd, m_have;
    logic [31:0] m_word, m_last_w;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return 8'h41 + 8'(n - 4'd10);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_timer = 0; m_fcnt = 0; m_src = 0; m_last_src = 0;
        m_rpend = 1; m_kpend = 0; m_snap = 0; m_fd = 0; m_have = 0;
        m_word = '0; m_last_w = '0;
    endtask

    task automatic model_step();
        bit wrap, tick, adv;
        logic [31:0] w;
        tick = 0;
        m_fd = 0;
        wrap = (m_timer == REFRESH_CYC - 1);
        m_timer = wrap ? 0 : m_timer + 1;
        if (mq.size() > 0) begin
            if (lcd_char_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    m_fd = 1; tick = 1;
                    m_have = 1; m_last_src = m_src; m_last_w = m_word;
                end
            end
        end else if (m_snap) begin
            m_snap = 0;
            adv = m_kpend;
            if (adv) m_src = (m_src + 1) % NUM_SRC;
            w = dbg_words[32*m_src +: 32];
            m_rpend = 0; m_kpend = 0;
            if (CHG && m_have && !adv && m_src == m_last_src && w == m_last_w) begin
                tick = 1;
            end else begin
                m_word = w;
                mq.push_back(8'h52);
                mq.push_back(hexc(4'(m_src)));
                mq.push_back(8'h3D);
                for (int i = 7; i >= 0; i--) mq.push_back(hexc(w[4*i +: 4]));
            end
        end else if (m_rpend) begin
            m_snap = 1;
        end
        if (tick && ROTATE_FRAMES != 0) begin
            m_fcnt++;
            if (m_fcnt == ROTATE_FRAMES) begin
                m_fcnt = 0; m_kpend = 1; m_rpend = 1;
            end
        end
        if (key_next) begin
            m_kpend = 1; m_rpend = 1; m_fcnt = 0;
        end
        if (wrap) m_rpend = 1;
    endtask

    task automatic model_check();
        check("mdl_valid", 32'(lcd_char_valid), 32'(mq.size() > 0));
        check("mdl_done", 32'(frame_done), 32'(m_fd));
        check("mdl_src", 32'(cur_src), 32'(m_src));
        if (mq.size() > 0) begin
            check("mdl_data", 32'(lcd_char_data), 32'(mq[0]));
            check("mdl_addr", 32'(lcd_char_addr), 32'(11 - mq.size()));
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_step();
        #1;
        model_check();
    endtask

    task automatic do_reset(input logic [31:0] w0);
        reset_n = 1'b0;
        key_next = 1'b0;
        lcd_char_ready = 1'b1;
        dbg_words = {32'h4444_0003, 32'h3333_0002, 32'h0000_00A5, w0};
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_valid", 32'(lcd_char_valid), 0);
        check("rst_data", 32'(lcd_char_data), 0);
        check("rst_addr", 32'(lcd_char_addr), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_src", 32'(cur_src), 0);
        @(negedge clk_in);
        reset_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rdy;
        logic       key;
        logic       v;
        logic [7:0] d;
        logic [4:0] a;
        logic       fd;
        logic [3:0] src;
    } vec_t;

    vec_t tbl[$];
    int   g[6];

    task automatic add(input logic rdy, input logic key, input logic v, input logic [7:0] d,
                       input logic [4:0] a, input logic fd, input logic [3:0] s);
        vec_t e;
        e.rdy = rdy; e.key = key; e.v = v; e.d = d; e.a = a; e.fd = fd; e.src = s;
        tbl.push_back(e);
    endtask

    task automatic add_chars(input string str, input int a0, input logic [3:0] s);
        for (int i = 0; i < str.len(); i++) add(1'b1, 1'b0, 1'b1, str[i], 5'(a0 + i), 1'b0, s);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            lcd_char_ready = tbl[i].rdy;
            key_next = tbl[i].key;
            cycle();
            check($sformatf("tbl%0d_valid", i), 32'(lcd_char_valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(tbl[i].fd));
            check($sformatf("tbl%0d_src", i), 32'(cur_src), 32'(tbl[i].src));
            if (tbl[i].v) begin
                check($sformatf("tbl%0d_data", i), 32'(lcd_char_data), 32'(tbl[i].d));
                check($sformatf("tbl%0d_addr", i), 32'(lcd_char_addr), 32'(tbl[i].a));
            end
        end
        key_next = 1'b0;
    endtask

    initial begin
        int st;
        int k;
        bit seen;
        string exp_s;

        // Group 0: plain frame with ready held high.
        g[0] = tbl.size();
        add(1, 0, 0, 0, 0, 0, 0);
        add_chars("R0=DEADBEEF", 0, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        // Group 1: ready low for 5 cycles while addr 3 is offered.
        g[1] = tbl.size();
        add(1, 0, 0, 0, 0, 0, 0);
        add_chars("R0=D", 0, 0);
        repeat (5) add(0, 0, 1, 8'h44, 5'd3, 0, 0);
        add_chars("EADBEEF", 4, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        // Group 2: key at addr 5, next frame shows source 1.
        g[2] = tbl.size();
        add(1, 0, 0, 0, 0, 0, 0);
        add_chars("R0=DEA", 0, 0);
        add(1, 1, 1, 8'h44, 5'd6, 0, 0);
        add_chars("BEEF", 7, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add_chars("R1=000000A5", 0, 1);
        add(1, 0, 0, 0, 0, 1, 1);
        // Group 3: restart after a mid-frame reset.
        g[3] = tbl.size();
        add(1, 0, 0, 0, 0, 0, 0);
        add_chars("R0=12", 0, 0);
        g[4] = tbl.size();

        reset_n = 1'b0;
        key_next = 1'b0;
        lcd_char_ready = 1'b1;
        dbg_words = '0;

        do_reset(32'hDEAD_BEEF);
        run_table(g[0], g[1]);
        do_reset(32'hDEAD_BEEF);
        run_table(g[1], g[2]);
        do_reset(32'hDEAD_BEEF);
        run_table(g[2], g[3]);

        // Mid-frame reset drops the outputs without waiting for a clock.
        do_reset(32'h1234_5678);
        repeat (8) cycle();
        check("t5_pre_valid", 32'(lcd_char_valid), 1);
        check("t5_pre_addr", 32'(lcd_char_addr), 6);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t5_async_valid", 32'(lcd_char_valid), 0);
        check("t5_async_data", 32'(lcd_char_data), 0);
        check("t5_async_addr", 32'(lcd_char_addr), 0);
        @(negedge clk_in);
        reset_n = 1'b1;
        run_table(g[3], g[4]);

`ifndef LCD_DBG_CHG_ONLY_EN
        // Two keys plus a rotate expiry on source 3 advance exactly once.
        do_reset(32'hCAFE_0000);
        st = 0;
        for (int c = 0; c < 3000 && st < 2; c++) begin
            if (st == 0 && m_src == 3 && mq.size() == 1 && m_fcnt == ROTATE_FRAMES - 1) begin
                key_next = 1'b1; st = 1;
            end else if (st == 1) begin
                key_next = 1'b1; st = 2;
            end else begin
                key_next = 1'b0;
            end
            cycle();
        end
        key_next = 1'b0;
        check("t4_reached", 32'(st), 2);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cycle();
            seen = lcd_char_valid;
        end
        check("t4_frame_started", 32'(seen), 1);
        check("t4_char0", 32'(lcd_char_data), 32'h52);
        check("t4_cur_src", 32'(cur_src), 0);
        cycle();
        check("t4_char1", 32'(lcd_char_data), 32'h30);
`else
        // Unchanged word is not resent; a changed word is.
        do_reset(32'h0BAD_F00D);
        repeat (14) cycle();
        seen = 0;
        repeat (3*REFRESH_CYC) begin
            cycle();
            if (lcd_char_valid) seen = 1;
        end
        check("t6_quiet", 32'(seen), 0);
        dbg_words[31:0] = 32'h0000_0001;
        seen = 0;
        for (int c = 0; c < 2*REFRESH_CYC && !seen; c++) begin
            cycle();
            seen = lcd_char_valid;
        end
        check("t6_resend", 32'(seen), 1);
        exp_s = "R0=00000001";
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t6_char%0d", i), 32'(lcd_char_data), 32'(exp_s[i]));
            check($sformatf("t6_addr%0d", i), 32'(lcd_char_addr), 32'(i));
            cycle();
        end
`endif

        // Random traffic against the frame model.
        do_reset($urandom);
        for (int c = 0; c < 4000; c++) begin
            lcd_char_ready = ($urandom_range(0, 3) != 0);
            key_next = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 49) == 0) begin
                k = $urandom_range(0, NUM_SRC - 1);
                dbg_words[32*k +: 32] = $urandom;
            end
            cycle();
        end
        key_next = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
